// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA controller channel arbiter.
package dmac_pkg;

  localparam int unsigned MAX_CH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    REQ_BUS = 3'd2,
    ACTIVE  = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } arb_state_t;

  // True in every state where this master holds or requests the AHB bus
  function automatic logic st_owns_bus(input arb_state_t s);
    return (s == REQ_BUS) || (s == ACTIVE) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational winner selection among eligible channels.
// Round-robin after last_idx by default; DMAC_FIXED_PRIO_EN selects lowest-index-wins.
module dmac_rr_picker
  import dmac_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_eligible,
  input  logic [IDX_W-1:0]  i_last_idx,
  output logic [IDX_W-1:0]  o_winner,
  output logic              o_valid
);

  logic w_found;

`ifdef DMAC_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last_idx;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_found && i_eligible[i]) begin
        w_found  = 1'b1;
        o_winner = IDX_W'(i);
      end
    end
  end
`else
  // First pass takes channels above last_idx; second pass wraps to the lowest index
  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_found && i_eligible[i] && (IDX_W'(i) > i_last_idx)) begin
        w_found  = 1'b1;
        o_winner = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_found && i_eligible[i]) begin
        w_found  = 1'b1;
        o_winner = IDX_W'(i);
      end
    end
  end
`endif

  assign o_valid = w_found;

endmodule

// File: rtl/dmac_channel_arbiter.sv
// Schedules peripheral DMA requests onto the single channel_ctrl and AHB master port.
// Build option: DMAC_FIXED_PRIO_EN switches the picker from round-robin to fixed priority.
module dmac_channel_arbiter
  import dmac_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_dma_req,
  input  logic [NUM_CH-1:0] i_ch_mask,
  input  logic              i_bus_grant,
  input  logic              i_ch_irq,
  input  logic [NUM_CH-1:0] i_irq_clr,
  output logic              o_bus_req,
  output logic              o_channel_en,
  output logic [IDX_W-1:0]  o_ch_sel,
  output logic [NUM_CH-1:0] o_dma_ack,
  output logic [NUM_CH-1:0] o_irq_status,
  output logic              o_irq
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [NUM_CH-1:0] w_eligible;
  logic [IDX_W-1:0]  w_winner;
  logic              w_win_valid;
  logic [IDX_W-1:0]  r_last_idx;
  logic [IDX_W-1:0]  r_ch_sel;
  logic [NUM_CH-1:0] w_sel_onehot;
  logic [NUM_CH-1:0] w_irq_status_nxt;
  logic [NUM_CH-1:0] w_dma_ack_nxt;
  logic              r_bus_req;
  logic              r_channel_en;
  logic [NUM_CH-1:0] r_dma_ack;
  logic [NUM_CH-1:0] r_irq_status;
  logic              r_irq;

  assign w_eligible   = i_dma_req & i_ch_mask;
  assign w_sel_onehot = NUM_CH'(1) << r_ch_sel;

  dmac_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .i_eligible (w_eligible),
    .i_last_idx (r_last_idx),
    .o_winner   (w_winner),
    .o_valid    (w_win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    w_next           = r_state;
    w_dma_ack_nxt    = '0;
    w_irq_status_nxt = r_irq_status & ~i_irq_clr;
    unique case (r_state)
      IDLE:    if (|w_eligible) w_next = ARB;
      ARB:     w_next = w_win_valid ? REQ_BUS : IDLE;
      REQ_BUS: if (i_bus_grant) w_next = ACTIVE;
      ACTIVE: begin
        if (i_ch_irq)         w_next = DONE;
        else if (!i_bus_grant) w_next = PAUSE;
      end
      PAUSE:   if (i_bus_grant) w_next = ACTIVE;
      DONE: begin
        w_next           = IDLE;
        w_irq_status_nxt = w_irq_status_nxt | w_sel_onehot;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == DONE) w_dma_ack_nxt = w_sel_onehot;
  end

  // ch_sel moves only on leaving ARB so the datapath mux is frozen for the whole transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_sel     <= '0;
      r_last_idx   <= IDX_W'(NUM_CH - 1);
      r_bus_req    <= 1'b0;
      r_channel_en <= 1'b0;
      r_dma_ack    <= '0;
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      if ((r_state == ARB) && w_win_valid) r_ch_sel <= w_winner;
      if (r_state == DONE) r_last_idx <= r_ch_sel;
      r_bus_req    <= st_owns_bus(w_next);
      r_channel_en <= (w_next == ACTIVE);
      r_dma_ack    <= w_dma_ack_nxt;
      r_irq_status <= w_irq_status_nxt;
      r_irq        <= |w_irq_status_nxt;
    end
  end

  assign o_bus_req    = r_bus_req;
  assign o_channel_en = r_channel_en;
  assign o_ch_sel     = r_ch_sel;
  assign o_dma_ack    = r_dma_ack;
  assign o_irq_status = r_irq_status;
  assign o_irq        = r_irq;

endmodule
